// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: widths, reset PC,
// PC-source select encodings and fetch FSM state encodings.
package if_fetch_stage_pkg;

    localparam int unsigned         WORD_SIZE = 16;
    localparam logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000;
    localparam int unsigned         PERF_W    = 16;

    // PC-source select driven by hazard detection / EX
    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_J   = 2'b11
    } pc_src_e;

    // Fetch FSM: issue request, wait for ack, hold buffered instruction
    typedef enum logic [1:0] {
        F_REQ  = 2'b00,
        F_WAIT = 2'b01,
        F_HOLD = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/if_next_pc_mux.sv
// Combinational next-PC select.
// Ports: pc_src (select), pc_plus1 / branch_target / jr_target / j_target
// (candidates), next_pc_c (selected next PC).
module if_next_pc_mux
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned WORD_SIZE = if_fetch_stage_pkg::WORD_SIZE
) (
    input  logic [1:0]           pc_src,
    input  logic [WORD_SIZE-1:0] pc_plus1,
    input  logic [WORD_SIZE-1:0] branch_target,
    input  logic [WORD_SIZE-1:0] jr_target,
    input  logic [WORD_SIZE-1:0] j_target,
    output logic [WORD_SIZE-1:0] next_pc_c
);

    always_comb begin
        next_pc_c = pc_plus1;
        case (pc_src)
            PCSRC_BR: next_pc_c = branch_target;
            PCSRC_JR: next_pc_c = jr_target;
            PCSRC_J:  next_pc_c = j_target;
            default:  next_pc_c = pc_plus1;
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Owns the PC, fetches through a req/ack memory handshake of variable
// latency and presents {inst, pc+1, valid} to decode.
// Ports:
//   clk, reset (async, active-high)
//   pc_write, ifid_write, pc_src, branch_target, jr_target, j_target,
//   is_halted                       : control from hazard unit / EX
//   i_mem_req, i_mem_addr, i_mem_ack, i_mem_rdata : instruction memory
//   ifid_inst, ifid_pc_plus1, ifid_valid          : IF/ID payload
// Optional macro FETCH_PERF_EN adds saturating fetch_count/squash_count.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned          WORD_SIZE = if_fetch_stage_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(if_fetch_stage_pkg::RESET_PC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_write,
    input  logic                 ifid_write,
    input  logic [1:0]           pc_src,
    input  logic [WORD_SIZE-1:0] branch_target,
    input  logic [WORD_SIZE-1:0] jr_target,
    input  logic [WORD_SIZE-1:0] j_target,
    input  logic                 is_halted,
    output logic                 i_mem_req,
    output logic [WORD_SIZE-1:0] i_mem_addr,
    input  logic                 i_mem_ack,
    input  logic [WORD_SIZE-1:0] i_mem_rdata,
    output logic [WORD_SIZE-1:0] ifid_inst,
    output logic [WORD_SIZE-1:0] ifid_pc_plus1,
`ifdef FETCH_PERF_EN
    output logic [PERF_W-1:0]    fetch_count,
    output logic [PERF_W-1:0]    squash_count,
`endif
    output logic                 ifid_valid
);

    fetch_state_e         state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] inst_buf;
    logic                 stale;

    logic [WORD_SIZE-1:0] pc_plus1_c;
    logic [WORD_SIZE-1:0] next_pc_c;
    logic                 redirect_c;
    logic                 transfer_c;

    assign pc_plus1_c = pc + WORD_SIZE'(1);
    // Halt is the only thing that can hold off a redirect
    assign redirect_c = (pc_src != PCSRC_SEQ) && !is_halted;
    assign transfer_c = (state == F_HOLD) && ifid_write && pc_write &&
                        !is_halted && !redirect_c;

    if_next_pc_mux #(.WORD_SIZE(WORD_SIZE)) u_next_pc_mux (
        .pc_src        (pc_src),
        .pc_plus1      (pc_plus1_c),
        .branch_target (branch_target),
        .jr_target     (jr_target),
        .j_target      (j_target),
        .next_pc_c     (next_pc_c)
    );

    // Fetch FSM, PC and IF/ID register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= F_REQ;
            pc            <= RESET_PC;
            inst_buf      <= '0;
            stale         <= 1'b0;
            i_mem_req     <= 1'b0;
            i_mem_addr    <= '0;
            ifid_inst     <= '0;
            ifid_pc_plus1 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            case (state)
                F_REQ: begin
                    // A redirect here must not issue a request to the old pc
                    if (redirect_c) begin
                        pc <= next_pc_c;
                    end else if (!is_halted) begin
                        i_mem_req  <= 1'b1;
                        i_mem_addr <= pc;
                        state      <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (i_mem_ack) begin
                        i_mem_req <= 1'b0;
                        stale     <= 1'b0;
                        if (stale || redirect_c) begin
                            state <= F_REQ;
                        end else begin
                            inst_buf <= i_mem_rdata;
                            state    <= F_HOLD;
                        end
                        if (redirect_c) begin
                            pc <= next_pc_c;
                        end
                    end else if (redirect_c) begin
                        // Request stays on the bus; its data is discarded on ack
                        stale <= 1'b1;
                        pc    <= next_pc_c;
                    end
                end
                F_HOLD: begin
                    if (redirect_c) begin
                        pc    <= next_pc_c;
                        state <= F_REQ;
                    end else if (transfer_c) begin
                        pc    <= next_pc_c;
                        state <= F_REQ;
                    end
                end
                default: state <= F_REQ;
            endcase

            // Redirect squashes the wrong-path instruction sitting in ID
            if (redirect_c) begin
                ifid_valid <= 1'b0;
                ifid_inst  <= '0;
            end else if (transfer_c) begin
                ifid_inst     <= inst_buf;
                ifid_pc_plus1 <= pc_plus1_c;
                ifid_valid    <= 1'b1;
            end else if (ifid_write && !is_halted && (state != F_HOLD)) begin
                ifid_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic drop_c;
    logic squash_ev_c;

    // One squash event per cycle: a fetch thrown away or a valid ID entry killed
    assign drop_c      = ((state == F_WAIT) && i_mem_ack && (stale || redirect_c)) ||
                         ((state == F_HOLD) && redirect_c);
    assign squash_ev_c = drop_c || (redirect_c && ifid_valid);

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count  <= '0;
            squash_count <= '0;
        end else begin
            if (transfer_c && (fetch_count != '1)) begin
                fetch_count <= fetch_count + PERF_W'(1);
            end
            if (squash_ev_c && (squash_count != '1)) begin
                squash_count <= squash_count + PERF_W'(1);
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
